// File: rtl/imem_loader.sv
// imem_loader: downloads a program from a UART byte stream into instruction
// memory. The stream is a 16-bit big-endian word count N, then N 32-bit
// big-endian words. The CPU is held in reset while loading. An abort is
// raised if N does not fit the memory or if the byte stream stalls too long.
module imem_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  imem_wen,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [2:0]            dbg_state_o
);

    // Compare width wide enough for both the 16-bit count and 2**ADDR_WIDTH.
    localparam int CW = ((ADDR_WIDTH > 16) ? ADDR_WIDTH : 16) + 1;
    // Timeout counter only ever holds 0 .. TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t                state_q;
    logic [7:0]            len_hi_q;
    logic [15:0]           len_q;
    logic [23:0]           shift_q;
    logic [1:0]            byte_cnt_q;
    logic [ADDR_WIDTH-1:0] word_idx_q;
    logic [TW-1:0]         tmo_q;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  hold_q;
    logic                  done_q;
    logic                  err_q;

    // Next-value helpers derived from the byte arriving this cycle.
    logic [15:0] len_d;
    logic [31:0] word_d;
    logic        len_too_big;
    logic        last_word;
    logic        tmo_hit;

    // Decode the incoming byte against the current partial length / word.
    always_comb begin
        len_d       = {len_hi_q, byte_data};
        word_d      = {shift_q, byte_data};
        len_too_big = (CW'(len_d) > (CW'(1) << ADDR_WIDTH));
        last_word   = (CW'(word_idx_q) == (CW'(len_q) - CW'(1)));
        tmo_hit     = (tmo_q == TW'(TIMEOUT - 1));
    end

    // Loader FSM: length capture, word assembly, memory writes, timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            len_hi_q   <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            tmo_q      <= '0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Write enable is a single-cycle pulse; only the 4th byte raises it.
            wen_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (load_start) begin
                        state_q    <= LEN_HI;
                        hold_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        word_idx_q <= '0;
                        byte_cnt_q <= '0;
                        tmo_q      <= '0;
                    end else if (state_q == DONE) begin
                        // Success flag trails the DONE entry by one cycle.
                        done_q <= 1'b1;
                    end
                end
                LEN_HI, LEN_LO, DATA: begin
                    if (byte_valid) begin
                        tmo_q <= '0;
                        if (state_q == LEN_HI) begin
                            len_hi_q <= byte_data;
                            state_q  <= LEN_LO;
                        end else if (state_q == LEN_LO) begin
                            len_q <= len_d;
                            if (len_d == 16'd0) begin
                                state_q <= DONE;
                                hold_q  <= 1'b0;
                            end else if (len_too_big) begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                            end else begin
                                state_q <= DATA;
                            end
                        end else begin
                            if (byte_cnt_q == 2'd3) begin
                                wen_q      <= 1'b1;
                                addr_q     <= word_idx_q;
                                wdata_q    <= word_d;
                                word_idx_q <= word_idx_q + ADDR_WIDTH'(1);
                                byte_cnt_q <= '0;
                                if (last_word) begin
                                    state_q <= DONE;
                                    hold_q  <= 1'b0;
                                end
                            end else begin
                                shift_q    <= {shift_q[15:0], byte_data};
                                byte_cnt_q <= byte_cnt_q + 2'd1;
                            end
                        end
                    end else if (tmo_hit) begin
                        // Stalled stream: drop any partial word and abort.
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_wen    = wen_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign cpu_hold    = hold_q;
    assign load_done   = done_q;
    assign load_err    = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (small memory, short timeout).
module tb_imem_loader;
  localparam int AW  = 4;
  localparam int TMO = 100;

  logic          clock = 1'b0;
  logic          reset;
  logic          load_start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          imem_wen;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int wr_seen  = 0;
  logic [AW+31:0] exp_q[$];

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .load_start(load_start),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .imem_wen(imem_wen), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write pulse must match the next expected (addr,data)
  always @(negedge clock) begin
    if (imem_wen === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) check_eq("unexpected_wen", {imem_addr, imem_wdata}, 64'hdead);
      else check_eq("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
    end
  end

  // driver tasks (all run at posedge+1)
  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    idle(1);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    idle(1);
    load_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_out"}, {imem_wen, imem_addr, imem_wdata, cpu_hold, load_done, load_err}, 64'd0);
  endtask

  // reference model: stream rules applied to a complete byte list
  task automatic model_load(input logic [7:0] b[$], output bit exp_done, output bit exp_err);
    int n;
    logic [31:0] w;
    logic [AW-1:0] a;
    n = b[0] * 256 + b[1];
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n == 0) exp_done = 1'b1;
    else if (n > (1 << AW)) exp_err = 1'b1;
    else begin
      for (int i = 0; i < n; i++) begin
        w = b[2+4*i] * 32'h0100_0000 + b[3+4*i] * 32'h0001_0000 + b[4+4*i] * 32'h100 + b[5+4*i];
        a = i[AW-1:0];
        exp_q.push_back({a, w});
      end
      exp_done = 1'b1;
    end
  endtask

  task automatic gen_bytes(output logic [7:0] b[$]);
    int n;
    int r;
    b = {};
    r = $urandom_range(0, 9);
    if (r == 0) n = 0;
    else if (r == 1) n = $urandom_range(17, 300);
    else n = $urandom_range(1, 16);
    b.push_back(8'(n >> 8));
    b.push_back(8'(n));
    if (n <= 16) for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_end(input string tag, input bit exp_done, input bit exp_err);
    for (int i = 0; i < 40 && !(load_done || load_err); i++) idle(1);
    check_eq({tag, "_end_reached"}, load_done | load_err, 1);
    check_eq({tag, "_done"}, load_done, exp_done);
    check_eq({tag, "_err"}, load_err, exp_err);
    check_eq({tag, "_hold"}, cpu_hold, exp_err);
    check_eq({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic run_load(input string tag, input logic [7:0] b[$], input int max_gap);
    bit ed, ee;
    int w0;
    model_load(b, ed, ee);
    w0 = wr_seen;
    pulse_start();
    check_eq({tag, "_start_flags"}, {cpu_hold, load_done, load_err}, 3'b100);
    foreach (b[i]) begin
      idle($urandom_range(0, max_gap));
      send_byte(b[i]);
    end
    wait_end(tag, ed, ee);
    check_eq({tag, "_wr_count"}, wr_seen - w0, (b.size() - 2) / 4);
  endtask

  initial begin
    logic [7:0] b[$];
    bit ed, ee;
    int w0;
    reset = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    idle(3);
    reset = 1'b0;
    check_reset_outputs("reset");

    // two-word directed load with exact latency checks
    b = {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    model_load(b, ed, ee);
    w0 = wr_seen;
    pulse_start();
    foreach (b[i]) send_byte(b[i]);
    check_eq("two_word_last_wen", {imem_wen, load_done}, 2'b10);
    idle(1);
    check_eq("two_word_done", {load_done, cpu_hold, load_err}, 3'b100);
    check_eq("two_word_pulses", wr_seen - w0, 2);
    check_eq("two_word_pending", exp_q.size(), 0);
    // stray byte in DONE is ignored
    send_byte(8'h55);
    idle(2);
    check_eq("done_stray_byte", {load_done, imem_wen}, 2'b10);

    // zero-length load: done two cycles after the second byte
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    check_eq("zero_len_early", load_done, 0);
    idle(1);
    check_eq("zero_len_done", {load_done, cpu_hold, load_err}, 3'b100);

    // count one past memory size aborts
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h11);
    check_eq("too_big_err", {load_err, cpu_hold, load_done}, 3'b110);

    // full-memory load (16 words)
    b = {8'h00, 8'h10};
    for (int i = 0; i < 64; i++) b.push_back(8'($urandom_range(0, 255)));
    run_load("full_mem", b, 1);

    // timeout after a partial word
    w0 = wr_seen;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    idle(TMO - 1);
    check_eq("tmo_not_yet", {load_err, cpu_hold}, 2'b01);
    idle(1);
    check_eq("tmo_err", {load_err, cpu_hold, load_done}, 3'b110);
    check_eq("tmo_no_write", wr_seen - w0, 0);

    // back-to-back bytes with load_start in the middle of the stream
    b = {8'h00, 8'h02};
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom_range(0, 255)));
    model_load(b, ed, ee);
    pulse_start();
    foreach (b[i]) begin
      byte_valid = 1'b1;
      byte_data  = b[i];
      load_start = (i == 5);
      idle(1);
    end
    byte_valid = 1'b0;
    load_start = 1'b0;
    wait_end("mid_start", ed, ee);

    // reset after 6 of 8 data bytes
    b = {8'h00, 8'h02};
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom_range(0, 255)));
    model_load(b, ed, ee);
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(b[i]);
    check_eq("rst_mid_word0_written", exp_q.size(), 1);
    do_reset();
    check_reset_outputs("rst_mid");
    exp_q = {};
    w0 = wr_seen;
    send_byte(8'h11);
    send_byte(8'h22);
    idle(4);
    check_eq("rst_mid_no_wen", wr_seen - w0, 0);
    check_eq("rst_mid_idle_flags", {cpu_hold, load_done, load_err}, 3'b000);
    b = {8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    run_load("after_reset", b, 0);

    // randomized loads
    for (int t = 0; t < 30; t++) begin
      gen_bytes(b);
      run_load($sformatf("rand%0d", t), b, 3);
      check_eq("rand_flags_exclusive", load_done & load_err, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // overall time guard
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
